// File: rtl/sram_req_rsp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_rsp_ctrl_if
// Description : Request, response and SRAM-wrapper signal bundle for
//               sram_req_rsp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_req_rsp_ctrl_if #(
    parameter int DATA_BIT = 128,
    parameter int ADDR_BIT = 7,
    parameter int CRD_BIT  = 3
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wen;
    logic [ADDR_BIT-1:0] req_addr;
    logic [DATA_BIT-1:0] req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_BIT-1:0] rsp_rdata;
    logic [ADDR_BIT-1:0] sram_addr;
    logic                sram_wen;
    logic                sram_ren;
    logic [DATA_BIT-1:0] sram_wdata;
    logic [DATA_BIT-1:0] sram_rdata;
    logic [CRD_BIT-1:0]  rd_credits;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wen, sram_ren,
               sram_wdata, rd_credits
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wen, sram_ren,
               sram_wdata, rd_credits
    );
endinterface
`default_nettype wire

// File: rtl/sram_req_rsp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_rsp_ctrl
// Description : Credit-admitted request/response front end for a fixed-latency
//               single-port SRAM wrapper, with a response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_req_rsp_ctrl #(
    parameter int DATA_BIT   = 128,
    parameter int DEPTH      = 128,
    parameter int ADDR_BIT   = $clog2(DEPTH),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sram_req_rsp_ctrl_if.slave    bus
);
    localparam int C_CRD_BIT = $clog2(FIFO_DEPTH + 1);
    localparam int C_PTR_BIT = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [C_PTR_BIT-1:0] C_LAST_PTR = C_PTR_BIT'(FIFO_DEPTH - 1);
    localparam logic [C_CRD_BIT-1:0] C_FULL_CRD = C_CRD_BIT'(FIFO_DEPTH);

    logic [RD_LAT-1:0]    r_pipe_q;
    logic [DATA_BIT-1:0]  r_mem_q [FIFO_DEPTH];
    logic [C_PTR_BIT-1:0] r_wr_ptr_q, r_rd_ptr_q;
    logic [C_CRD_BIT-1:0] r_count_q, r_credits_q;
    logic [C_CRD_BIT-1:0] w_count_d, w_credits_d;

    logic w_ready, w_acc, w_rd_acc, w_push, w_pop, w_empty;

    // Reset gates readiness combinationally so nothing reaches the SRAM during rst.
    assign w_ready  = ~rst & (bus.req_wen | (r_credits_q != '0));
    assign w_acc    = bus.req_valid & w_ready;
    assign w_rd_acc = w_acc & ~bus.req_wen;
    assign w_push   = r_pipe_q[RD_LAT-1];
    assign w_empty  = (r_count_q == '0);
    assign w_pop    = ~w_empty & bus.rsp_ready;

    assign bus.req_ready  = w_ready;
    assign bus.sram_addr  = bus.req_addr;
    assign bus.sram_wdata = bus.req_wdata;
    assign bus.sram_wen   = w_acc & bus.req_wen;
    assign bus.sram_ren   = w_rd_acc;
    assign bus.rsp_valid  = ~w_empty;
    assign bus.rsp_rdata  = r_mem_q[r_rd_ptr_q];
    assign bus.rd_credits = r_credits_q;

    always_comb begin
        w_count_d   = r_count_q;
        w_credits_d = r_credits_q;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
        case ({w_rd_acc, w_pop})
            2'b10:   w_credits_d = r_credits_q - 1'b1;
            2'b01:   w_credits_d = r_credits_q + 1'b1;
            default: w_credits_d = r_credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_q <= '0;
        end else begin
            r_pipe_q[0] <= w_rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_q[i] <= r_pipe_q[i-1];
            end
        end
    end

    // Storage is cleared so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_credits_q <= C_FULL_CRD;
        end else begin
            if (w_push) begin
                r_mem_q[r_wr_ptr_q] <= bus.sram_rdata;
                r_wr_ptr_q <= (r_wr_ptr_q == C_LAST_PTR) ? '0 : r_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr_q <= (r_rd_ptr_q == C_LAST_PTR) ? '0 : r_rd_ptr_q + 1'b1;
            end
            r_count_q   <= w_count_d;
            r_credits_q <= w_credits_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sram_req_rsp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_req_rsp_ctrl
// Description : Self-checking bench: SRAM wrapper model plus a transaction-level
//               reference of outstanding reads, credits and response timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_req_rsp_ctrl;
    localparam int DATA_BIT   = 128;
    localparam int DEPTH      = 128;
    localparam int ADDR_BIT   = 7;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CRD_BIT    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_req_rsp_ctrl_if #(.DATA_BIT(DATA_BIT), .ADDR_BIT(ADDR_BIT), .CRD_BIT(CRD_BIT)) bus ();

    sram_req_rsp_ctrl #(
        .DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Wrapper model: write commits at its accept edge, read data appears RD_LAT edges later.
    logic [DATA_BIT-1:0] sram_mem [DEPTH];
    logic [DATA_BIT-1:0] rd_pipe  [RD_LAT];
    always @(posedge clk) begin
        if (bus.sram_wen) sram_mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_ren) rd_pipe[0] <= sram_mem[bus.sram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.sram_rdata = rd_pipe[RD_LAT-1];

    typedef struct {
        logic [DATA_BIT-1:0] data;
        int                  t_acc;
    } rd_ent_t;

    rd_ent_t             outq[$];
    logic [DATA_BIT-1:0] ref_mem [DEPTH];
    int                  cyc = 0;
    int                  n_vec = 0;
    int                  n_err = 0;

    task automatic chk(input string tag, input logic [DATA_BIT-1:0] obs,
                       input logic [DATA_BIT-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive at negedge, check settled outputs, then model the edge.
    task automatic step(input logic v, input logic w, input logic [ADDR_BIT-1:0] a,
                        input logic [DATA_BIT-1:0] d, input logic rr);
        logic exp_rdy, due;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_wen   = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        exp_rdy = w | (outq.size() < FIFO_DEPTH);
        due     = (outq.size() > 0) && (cyc >= outq[0].t_acc + RD_LAT);
        chk("req_ready",  128'(bus.req_ready), 128'(exp_rdy));
        chk("sram_wen",   128'(bus.sram_wen),  128'(v & exp_rdy & w));
        chk("sram_ren",   128'(bus.sram_ren),  128'(v & exp_rdy & ~w));
        chk("sram_addr",  128'(bus.sram_addr), 128'(a));
        chk("rd_credits", 128'(bus.rd_credits), 128'(FIFO_DEPTH - outq.size()));
        chk("rsp_valid",  128'(bus.rsp_valid), 128'(due));
        if (due) chk("rsp_rdata", bus.rsp_rdata, outq[0].data);
        @(posedge clk);
        cyc++;
        if (due && rr) void'(outq.pop_front());
        if (v && exp_rdy) begin
            if (w) ref_mem[a] = d;
            else   outq.push_back('{ref_mem[a], cyc});
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr);
    endtask

    function automatic logic [DATA_BIT-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DATA_BIT-1:0] pat;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1;
        #1;
        chk("rst_rsp_valid",  128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_rdata",  bus.rsp_rdata, '0);
        chk("rst_rd_credits", 128'(bus.rd_credits), 128'(FIFO_DEPTH));
        chk("rst_req_ready",  128'(bus.req_ready), 128'(0));
        chk("rst_sram_ren",   128'(bus.sram_ren), 128'(0));
        rst = 1'b0;
        bus.req_valid = 1'b0;

        // Preload the address range used by the random phase.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, ADDR_BIT'(i), rnd_word(), 1'b1);

        // Single read after write.
        pat = {4{32'hA5A5_A5A5}};
        step(1'b1, 1'b1, 7'd5, pat, 1'b1);
        step(1'b1, 1'b0, 7'd5, '0, 1'b1);
        idle(4, 1'b1);

        // Backpressure fill, credit release, write with zero credits.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, ADDR_BIT'(i), '0, 1'b0);
        step(1'b1, 1'b0, 7'd6, '0, 1'b1);
        step(1'b1, 1'b0, 7'd6, '0, 1'b0);
        step(1'b1, 1'b1, 7'd7, rnd_word(), 1'b0);
        idle(6, 1'b1);
        step(1'b1, 1'b0, 7'd7, '0, 1'b1);
        idle(4, 1'b1);

        // Sustained read stream with the consumer always ready.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, ADDR_BIT'(i % 16), '0, 1'b1);
        idle(4, 1'b1);

        // Reset with two reads in flight: they must be dropped.
        step(1'b1, 1'b0, 7'd1, '0, 1'b0);
        step(1'b1, 1'b0, 7'd2, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        #1;
        chk("midrst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("midrst_req_ready", 128'(bus.req_ready), 128'(0));
        chk("midrst_sram_ren",  128'(bus.sram_ren), 128'(0));
        outq.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        idle(6, 1'b1);

        // Randomized traffic; valid, write and ready probabilities redrawn every 150 cycles.
        for (int ph = 0; ph < 12; ph++) begin
            int pv, pw, pr;
            pv = $urandom_range(20, 100);
            pw = $urandom_range(0, 60);
            pr = $urandom_range(0, 100);
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pw),
                     ADDR_BIT'($urandom_range(0, 15)), rnd_word(),
                     ($urandom_range(0, 99) < pr));
            end
        end
        idle(10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_req_rsp_ctrl.md
Name: sram_req_rsp_ctrl

Overview:
- Request/response front end for the single-port SRAM wrapper (sram_sp_sky130).
- Accepts a valid/ready stream of read and write requests and drives the wrapper's addr/wen/ren/wdata ports.
- Tracks the wrapper's fixed read latency and captures returning rdata into a response FIFO, so a downstream consumer can apply backpressure without losing data.
- Credit-based admission makes FIFO overflow impossible by construction.

Parameters:
- DATA_BIT, 128, word width; must be a multiple of 32, matching the SRAM wrapper.
- DEPTH, 128, SRAM word count.
- ADDR_BIT, $clog2(DEPTH), address width.
- RD_LAT, 2, cycles from an accepted read to valid sram_rdata (macro read plus the wrapper's output register); must be ≥1.
- FIFO_DEPTH, 4, response FIFO entries; also the read credit pool. Must be ≥1 and need not be a power of two.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_BIT  word address.
- req_wdata  in  DATA_BIT  write data.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_BIT  read data (FIFO head).
- sram_addr  out  ADDR_BIT  to wrapper addr.
- sram_wen  out  1  to wrapper wen.
- sram_ren  out  1  to wrapper ren.
- sram_wdata  out  DATA_BIT  to wrapper wdata.
- sram_rdata  in  DATA_BIT  from wrapper rdata.
- rd_credits  out  $clog2(FIFO_DEPTH+1)  free read credits (status).

Behaviour:
- Accept condition: acc = req_valid & req_ready.
- req_ready is combinational: 1 when req_wen=1, otherwise (rd_credits != 0). Writes never consume credits and are always ready.
- SRAM drive is combinational, with no added latency:
  - sram_addr = req_addr and sram_wdata = req_wdata (pass-through, even when idle).
  - sram_wen = acc & req_wen.
  - sram_ren = acc & ~req_wen.
  - sram_wen and sram_ren are never both 1.
- In-flight tracking:
  - An RD_LAT-deep shift register of valid bits; bit 0 loads sram_ren each edge.
  - When the last stage is 1, sram_rdata is pushed into the FIFO at that edge.
  - Latency: a read accepted at edge T is pushed at edge T+RD_LAT; rsp_valid is 1 from cycle T+RD_LAT onward (after that edge). Minimum accept-to-rsp_valid is RD_LAT+1 clock edges counting the accept edge.
- Response FIFO:
  - Registered storage with wrap-around read and write pointers.
  - rsp_valid = ~empty; rsp_rdata = head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same edge are both performed; count is unchanged.
- Credit counter:
  - Reset value is FIFO_DEPTH.
  - Decrement on a read accept; increment on a pop.
  - Both events in the same edge leave the count unchanged.
  - Invariant: rd_credits + inflight + fifo_count = FIFO_DEPTH. Push-when-full is unreachable; assert it in verification.
  - At rd_credits=0, a pop in cycle N makes req_ready=1 for reads in cycle N+1, never in the same cycle (no combinational rsp_ready→req_ready path).
- Ordering:
  - Responses return strictly in read-acceptance order.
  - A write accepted after a read does not affect that read's data.
  - A read accepted after a write to the same address returns the new data (the wrapper is single-port; write commits at its accept edge).
- Reset (async assert, sync deassert assumed upstream):
  - In-flight bits cleared, FIFO pointers and count cleared, rd_credits=FIFO_DEPTH.
  - rsp_valid=0, rsp_rdata=0.
  - A read in flight when rst asserts is discarded and never pushed.
  - Combinational sram_wen/sram_ren are 0 while rst=1; req_ready=0 during reset.
- No internal state machine beyond pointers, counters and shift register; no idle or busy states.

Test Plan:
- Single read: write 0xA5A5… to addr 5, then read addr 5 with rsp_ready=1 → sram_ren pulses 1 cycle; rsp_valid rises exactly RD_LAT edges after the accept edge with rsp_rdata=0xA5A5…; rd_credits goes 4→3→4.
- Backpressure fill: rsp_ready=0, issue 6 back-to-back reads of addr 0..5 → exactly 4 accepted; req_ready=0 after the 4th; FIFO holds data of addr 0..3 in order; no overflow.
- Credit release: from the full state, pulse rsp_ready for one cycle → one pop (addr 0 data); req_ready for reads rises next cycle; next read accepted; order preserved.
- Write while credits=0: rd_credits=0, req_valid=1, req_wen=1, addr 7 → accepted (req_ready=1), sram_wen=1; a later read of addr 7 returns the written value.
- Simultaneous pop and accept: steady stream of reads with rsp_ready=1 → one accept per cycle sustained, rd_credits constant at FIFO_DEPTH-RD_LAT-1 in steady state, no bubbles.
- Reset mid-flight: assert rst one cycle after two reads are accepted → rsp_valid=0 immediately; after release rd_credits=4, FIFO empty, no stale response ever appears.
